// File: rtl/instr_encoder.sv
// instr_encoder: turns a stream of operation requests into 32-bit MIPS-style
// instruction words, buffers them in a small FIFO and writes them into an
// instruction memory. Each write uses a simple we/ready handshake, and the
// write address advances by one word per completed write.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW:0]   WC_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   WC_MAX   = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        K_R,
        K_I,
        K_J,
        K_ILL
    } kind_e;

    state_e        state_q, state_d;

    logic [31:0]   fifoMem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   wordCount_q, wordCount_d;
    logic          err_q, err_d;

    kind_e         encKind;
    logic [5:0]    encCode;
    logic [31:0]   encWord;
    logic          encLegal;

    logic          fifoEmpty;
    logic          canAccept;
    logic          accept;
    logic          push;
    logic          pop;
    logic          startLoad;

    assign fifoEmpty = (count_q == '0);
    assign canAccept = (state_q == LOAD) && (count_q < FULL_CNT);
    assign accept    = in_valid && canAccept;
    assign push      = accept && encLegal;
    assign pop       = mem_we && mem_ready;

    assign in_ready   = canAccept;
    assign mem_we     = !fifoEmpty && ((state_q == LOAD) || (state_q == DRAIN));
    assign mem_addr   = addr_q;
    assign mem_wdata  = fifoEmpty ? 32'h0 : fifoMem_q[rdPtr_q];
    assign word_count = wordCount_q;
    assign err        = err_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

    // Decode the operation select into an instruction class and its funct/opcode field
    always_comb begin
        encKind = K_ILL;
        encCode = 6'b000000;
        case (in_op)
            5'd0:    begin encKind = K_R; encCode = 6'b100000; end
            5'd1:    begin encKind = K_R; encCode = 6'b100010; end
            5'd2:    begin encKind = K_R; encCode = 6'b101010; end
            5'd3:    begin encKind = K_R; encCode = 6'b100100; end
            5'd4:    begin encKind = K_R; encCode = 6'b011111; end
            5'd5:    begin encKind = K_R; encCode = 6'b011110; end
            5'd6:    begin encKind = K_R; encCode = 6'b100101; end
            5'd7:    begin encKind = K_R; encCode = 6'b100110; end
            5'd8:    begin encKind = K_R; encCode = 6'b011101; end
            5'd9:    begin encKind = K_R; encCode = 6'b100111; end
            5'd10:   begin encKind = K_R; encCode = 6'b101000; end
            5'd11:   begin encKind = K_R; encCode = 6'b001000; end
            5'd12:   begin encKind = K_I; encCode = 6'b100011; end
            5'd13:   begin encKind = K_I; encCode = 6'b101011; end
            5'd14:   begin encKind = K_I; encCode = 6'b001100; end
            5'd15:   begin encKind = K_I; encCode = 6'b001101; end
            5'd16:   begin encKind = K_I; encCode = 6'b000100; end
            5'd17:   begin encKind = K_I; encCode = 6'b000101; end
            5'd18:   begin encKind = K_I; encCode = 6'b001111; end
            5'd19:   begin encKind = K_I; encCode = 6'b010000; end
            5'd20:   begin encKind = K_I; encCode = 6'b010001; end
            5'd21:   begin encKind = K_I; encCode = 6'b010010; end
            5'd22:   begin encKind = K_I; encCode = 6'b010011; end
            5'd23:   begin encKind = K_I; encCode = 6'b010100; end
            5'd24:   begin encKind = K_J; encCode = 6'b000001; end
            5'd25:   begin encKind = K_J; encCode = 6'b000010; end
            5'd26:   begin encKind = K_J; encCode = 6'b000011; end
            default: begin encKind = K_ILL; encCode = 6'b000000; end
        endcase
    end

    // Assemble the 32-bit word for the decoded class; illegal selects are flagged
    always_comb begin
        encWord  = 32'h0;
        encLegal = 1'b1;
        case (encKind)
            K_R:     encWord = {6'b000000, in_rs, in_rt, in_rd, in_shamt, encCode};
            K_I:     encWord = {encCode, in_rs, in_rt, in_imm};
            K_J:     encWord = {encCode, in_target};
            default: begin
                encWord  = 32'h0;
                encLegal = 1'b0;
            end
        endcase
    end

    // Control FSM next state: a start only matters in IDLE, the last accepted op ends loading
    always_comb begin
        state_d   = state_q;
        startLoad = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    startLoad = 1'b1;
                end
            end
            LOAD: begin
                if (accept && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifoEmpty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next state: FIFO pointers/count, write address, word counter and sticky error
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        addr_d      = addr_q;
        wordCount_d = wordCount_q;
        err_d       = err_q;

        if (push) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end

        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
            addr_d  = addr_q + ADDR_ONE;
            if (wordCount_q != WC_MAX) begin
                wordCount_d = wordCount_q + WC_ONE;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (accept && !encLegal) begin
            err_d = 1'b1;
        end

        if (startLoad) begin
            addr_d      = base_addr;
            wordCount_d = '0;
            err_d       = 1'b0;
        end
    end

    // FIFO storage; contents are don't-care while empty because the read side is gated
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= encWord;
        end
    end

    // State register; reset drops any queued words and returns to IDLE at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            wordCount_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            wordCount_q <= wordCount_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scenarios for instr_encoder with hand-computed
// instruction words and write addresses.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_op;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [4:0]    in_shamt;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          in_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] logAddr [$];
    logic [31:0]   logData [$];

    instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_shamt   (in_shamt),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .in_last    (in_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Record every completed memory write as seen just before the clock edge
    always @(posedge clk) begin
        if (rst_n && mem_we && mem_ready) begin
            logAddr.push_back(mem_addr);
            logData.push_back(mem_wdata);
        end
    end

    // Hard stop if something hangs despite the bounded waits
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    task automatic drive_op(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                            input logic [25:0] tgt, input logic last);
        int waited = 0;
        in_op     = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_shamt  = sh;
        in_imm    = imm;
        in_target = tgt;
        in_last   = last;
        in_valid  = 1'b1;
        while (in_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept_timeout op=%0d in_ready=%b required 1", op, in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && done !== 1'b1; i++) begin
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_pulse got %b required 1", done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks += 8;
        if (in_ready !== 1'b0)    begin errors++; $display("[TB] FAIL rst_in_ready got %b required 0", in_ready); end
        if (mem_we !== 1'b0)      begin errors++; $display("[TB] FAIL rst_mem_we got %b required 0", mem_we); end
        if (mem_addr !== '0)      begin errors++; $display("[TB] FAIL rst_mem_addr got %h required 0", mem_addr); end
        if (mem_wdata !== 32'h0)  begin errors++; $display("[TB] FAIL rst_mem_wdata got %h required 0", mem_wdata); end
        if (word_count !== '0)    begin errors++; $display("[TB] FAIL rst_word_count got %0d required 0", word_count); end
        if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL rst_busy got %b required 0", busy); end
        if (done !== 1'b0)        begin errors++; $display("[TB] FAIL rst_done got %b required 0", done); end
        if (err !== 1'b0)         begin errors++; $display("[TB] FAIL rst_err got %b required 0", err); end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset busy=%b in_ready=%b required 0/0", busy, in_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0]   expD [2] = '{32'h00221820, 32'h8C850008};
        logic [AW-1:0] expA [2] = '{10'h010, 10'h011};
        logData.delete();
        logAddr.delete();
        mem_ready = 1'b1;
        do_start(10'h010);
        checks += 3;
        if (busy !== 1'b1)         begin errors++; $display("[TB] FAIL basic_busy got %b required 1", busy); end
        if (mem_addr !== 10'h010)  begin errors++; $display("[TB] FAIL basic_start_addr got %h required 010", mem_addr); end
        if (word_count !== '0)     begin errors++; $display("[TB] FAIL basic_start_count got %0d required 0", word_count); end
        drive_op(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        drive_op(5'd12, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b1);
        wait_done();
        checks += 2;
        if (word_count !== 11'd2)  begin errors++; $display("[TB] FAIL basic_word_count got %0d required 2", word_count); end
        if (logData.size() != 2)   begin errors++; $display("[TB] FAIL basic_write_total got %0d required 2", logData.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= logData.size()) begin
                errors++;
                $display("[TB] FAIL basic_write%0d missing, required %h@%h", i, expD[i], expA[i]);
            end else if (logData[i] !== expD[i] || logAddr[i] !== expA[i]) begin
                errors++;
                $display("[TB] FAIL basic_write%0d got %h@%h required %h@%h", i, logData[i], logAddr[i], expD[i], expA[i]);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_back_to_idle done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] expD [5] = '{32'h00221822, 32'h0022182A, 32'h0007415F, 32'h00221824, 32'h30221234};
        logData.delete();
        logAddr.delete();
        mem_ready = 1'b0;
        do_start(10'h100);
        drive_op(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        drive_op(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        drive_op(5'd4, 5'd0, 5'd7, 5'd8, 5'd5, 16'h0, 26'h0, 1'b0);
        drive_op(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        in_op    = 5'd14;
        in_rs    = 5'd1;
        in_rt    = 5'd2;
        in_imm   = 16'h1234;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checks += 4;
            if (in_ready !== 1'b0)           begin errors++; $display("[TB] FAIL bp_full_ready c%0d got %b required 0", c, in_ready); end
            if (mem_we !== 1'b1)             begin errors++; $display("[TB] FAIL bp_hold_we c%0d got %b required 1", c, mem_we); end
            if (mem_addr !== 10'h100)        begin errors++; $display("[TB] FAIL bp_hold_addr c%0d got %h required 100", c, mem_addr); end
            if (mem_wdata !== 32'h00221822)  begin errors++; $display("[TB] FAIL bp_hold_data c%0d got %h required 00221822", c, mem_wdata); end
            tick();
        end
        mem_ready = 1'b1;
        drive_op(5'd14, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1);
        wait_done();
        checks += 2;
        if (word_count !== 11'd5)  begin errors++; $display("[TB] FAIL bp_word_count got %0d required 5", word_count); end
        if (logData.size() != 5)   begin errors++; $display("[TB] FAIL bp_write_total got %0d required 5", logData.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= logData.size()) begin
                errors++;
                $display("[TB] FAIL bp_write%0d missing, required %h", i, expD[i]);
            end else if (logData[i] !== expD[i] || logAddr[i] !== 10'(10'h100 + i)) begin
                errors++;
                $display("[TB] FAIL bp_write%0d got %h@%h required %h@%h", i, logData[i], logAddr[i], expD[i], 10'(10'h100 + i));
            end
        end
        tick();
    endtask

    task automatic test_illegal();
        logData.delete();
        logAddr.delete();
        mem_ready = 1'b1;
        do_start(10'h020);
        drive_op(5'd28, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        checks += 3;
        if (err !== 1'b1)          begin errors++; $display("[TB] FAIL ill_err_set got %b required 1", err); end
        if (mem_we !== 1'b0)       begin errors++; $display("[TB] FAIL ill_no_write got %b required 0", mem_we); end
        if (word_count !== '0)     begin errors++; $display("[TB] FAIL ill_count got %0d required 0", word_count); end
        drive_op(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000040, 1'b1);
        wait_done();
        checks += 4;
        if (err !== 1'b1)          begin errors++; $display("[TB] FAIL ill_err_sticky got %b required 1", err); end
        if (word_count !== 11'd1)  begin errors++; $display("[TB] FAIL ill_word_count got %0d required 1", word_count); end
        if (logData.size() != 1)   begin errors++; $display("[TB] FAIL ill_write_total got %0d required 1", logData.size()); end
        if (logData.size() < 1 || logData[0] !== 32'h08000040 || logAddr[0] !== 10'h020) begin
            errors++;
            $display("[TB] FAIL ill_jump_word got %h@%h required 08000040@020",
                     (logData.size() > 0) ? logData[0] : 32'hx, (logAddr.size() > 0) ? logAddr[0] : 10'hx);
        end
        tick();
    endtask

    task automatic test_wrap();
        logData.delete();
        logAddr.delete();
        mem_ready = 1'b1;
        do_start(10'h3FF);
        checks++;
        if (err !== 1'b0)          begin errors++; $display("[TB] FAIL wrap_err_cleared got %b required 0", err); end
        drive_op(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        drive_op(5'd12, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b1);
        wait_done();
        checks += 4;
        if (word_count !== 11'd2)  begin errors++; $display("[TB] FAIL wrap_word_count got %0d required 2", word_count); end
        if (mem_addr !== 10'h001)  begin errors++; $display("[TB] FAIL wrap_final_addr got %h required 001", mem_addr); end
        if (logData.size() < 1 || logData[0] !== 32'h00221820 || logAddr[0] !== 10'h3FF) begin
            errors++;
            $display("[TB] FAIL wrap_write0 got %h@%h required 00221820@3ff",
                     (logData.size() > 0) ? logData[0] : 32'hx, (logAddr.size() > 0) ? logAddr[0] : 10'hx);
        end
        if (logData.size() < 2 || logData[1] !== 32'h8C850008 || logAddr[1] !== 10'h000) begin
            errors++;
            $display("[TB] FAIL wrap_write1 got %h@%h required 8c850008@000",
                     (logData.size() > 1) ? logData[1] : 32'hx, (logAddr.size() > 1) ? logAddr[1] : 10'hx);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] expD [6] = '{32'h00221820, 32'h00221822, 32'h0022182A,
                                  32'h00221824, 32'h00221825, 32'h8C850008};
        logData.delete();
        logAddr.delete();
        mem_ready = 1'b0;
        do_start(10'h200);
        drive_op(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        drive_op(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        drive_op(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        checks += 2;
        if (in_ready !== 1'b1)           begin errors++; $display("[TB] FAIL b2b_ready_at_3 got %b required 1", in_ready); end
        if (mem_wdata !== 32'h00221820)  begin errors++; $display("[TB] FAIL b2b_head_before got %h required 00221820", mem_wdata); end
        mem_ready = 1'b1;
        drive_op(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        mem_ready = 1'b0;
        checks += 3;
        if (in_ready !== 1'b1)           begin errors++; $display("[TB] FAIL b2b_ready_after got %b required 1", in_ready); end
        if (mem_addr !== 10'h201)        begin errors++; $display("[TB] FAIL b2b_addr_after got %h required 201", mem_addr); end
        if (mem_wdata !== 32'h00221822)  begin errors++; $display("[TB] FAIL b2b_head_after got %h required 00221822", mem_wdata); end
        drive_op(5'd6, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        checks++;
        if (in_ready !== 1'b0)           begin errors++; $display("[TB] FAIL b2b_full_after_push got %b required 0", in_ready); end
        mem_ready = 1'b1;
        drive_op(5'd12, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b1);
        wait_done();
        checks += 2;
        if (word_count !== 11'd6)  begin errors++; $display("[TB] FAIL b2b_word_count got %0d required 6", word_count); end
        if (logData.size() != 6)   begin errors++; $display("[TB] FAIL b2b_write_total got %0d required 6", logData.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= logData.size()) begin
                errors++;
                $display("[TB] FAIL b2b_write%0d missing, required %h", i, expD[i]);
            end else if (logData[i] !== expD[i] || logAddr[i] !== 10'(10'h200 + i)) begin
                errors++;
                $display("[TB] FAIL b2b_write%0d got %h@%h required %h@%h", i, logData[i], logAddr[i], expD[i], 10'(10'h200 + i));
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logData.delete();
        logAddr.delete();
        mem_ready = 1'b0;
        do_start(10'h050);
        drive_op(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        drive_op(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        drive_op(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        checks++;
        if (mem_we !== 1'b1)      begin errors++; $display("[TB] FAIL mid_we_before got %b required 1", mem_we); end
        rst_n = 1'b0;
        #1;
        checks += 8;
        if (in_ready !== 1'b0)    begin errors++; $display("[TB] FAIL mid_in_ready got %b required 0", in_ready); end
        if (mem_we !== 1'b0)      begin errors++; $display("[TB] FAIL mid_mem_we got %b required 0", mem_we); end
        if (mem_addr !== '0)      begin errors++; $display("[TB] FAIL mid_mem_addr got %h required 0", mem_addr); end
        if (mem_wdata !== 32'h0)  begin errors++; $display("[TB] FAIL mid_mem_wdata got %h required 0", mem_wdata); end
        if (word_count !== '0)    begin errors++; $display("[TB] FAIL mid_word_count got %0d required 0", word_count); end
        if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL mid_busy got %b required 0", busy); end
        if (done !== 1'b0)        begin errors++; $display("[TB] FAIL mid_done got %b required 0", done); end
        if (err !== 1'b0)         begin errors++; $display("[TB] FAIL mid_err got %b required 0", err); end
        tick();
        tick();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (mem_we !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mid_quiet c%0d mem_we=%b busy=%b required 0/0", c, mem_we, busy);
            end
        end
        checks++;
        if (logData.size() != 0)  begin errors++; $display("[TB] FAIL mid_no_writes got %0d required 0", logData.size()); end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_rd     = '0;
        in_shamt  = '0;
        in_imm    = '0;
        in_target = '0;
        in_last   = 1'b0;
        mem_ready = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_illegal();
        test_wrap();
        test_back_to_back();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries (power of 2, >=2).
REQ-002 Parameter: AW, 10, instruction-memory word-address width.
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: start  in  1  one-cycle pulse begins a program load.
REQ-006 Port: base_addr  in  AW  first write address, sampled on accepted start.
REQ-007 Port: in_valid  in  1  producer offers an operation.
REQ-008 Port: in_ready  out  1  block accepts the operation this cycle.
REQ-009 Port: in_op  in  5  operation select (see REQ-017..019).
REQ-010 Port: in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
REQ-011 Port: in_imm  in  16  immediate; in_target  in  26  jump target.
REQ-012 Port: in_last  in  1  marks final operation of program.
REQ-013 Port: mem_we  out  1  write request to instruction memory.
REQ-014 Port: mem_addr  out  AW; mem_wdata  out  32  write address/word.
REQ-015 Port: mem_ready  in  1  memory accepts write this cycle.
REQ-016 Port: busy, done, err  out  1 each; word_count  out  AW+1  words written.

Function
REQ-017 SHALL encode in_op 0..11 as R-type {6'b000000, rs, rt, rd, shamt, funct}, funct in order: 100000, 100010, 101010, 100100, 011111, 011110, 100101, 100110, 011101, 100111, 101000, 001000.
REQ-018 SHALL encode in_op 12..23 as I-type {opcode, rs, rt, imm}, opcode in order: 100011, 101011, 001100, 001101, 000100, 000101, 001111, 010000, 010001, 010010, 010011, 010100.
REQ-019 SHALL encode in_op 24..26 as J-type {opcode, target}, opcode 000001, 000010, 000011; in_op 27..31 illegal.
REQ-020 SHALL implement FSM IDLE, LOAD, DRAIN, DONE; busy = (state != IDLE).
REQ-021 IDLE: in_ready=0, mem_we=0; start -> LOAD, mem_addr<=base_addr, word_count<=0, err<=0; start ignored in other states.
REQ-022 in_ready = (state==LOAD) && FIFO count < DEPTH, from registered count only (no same-cycle pop bypass).
REQ-023 Accept = in_valid && in_ready; legal word pushed same edge; mem_we may assert no earlier than next cycle (latency 1).
REQ-024 Illegal in_op accepted: word discarded, err<=1 (sticky until next start), no write, word_count unchanged.
REQ-025 Accept with in_last=1 (legal or illegal) -> DRAIN; in_ready=0 in DRAIN and DONE.
REQ-026 mem_we = FIFO non-empty && state in {LOAD, DRAIN}; mem_wdata = FIFO head.
REQ-027 Write completes when mem_we && mem_ready: pop, mem_addr<=mem_addr+1 modulo 2^AW, word_count+1.
REQ-028 mem_we, mem_addr, mem_wdata SHALL hold stable while mem_we && !mem_ready.
REQ-029 Simultaneous push and pop: FIFO count unchanged, order preserved.
REQ-030 DRAIN -> DONE when FIFO empty and no write pending; DONE lasts 1 cycle, done=1, -> IDLE.
REQ-031 mem_addr wraps 2^AW-1 -> 0 without error; word_count saturates at 2^AW.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, FIFO empty, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, busy=0, done=0, err=0.
REQ-033 Reset mid-LOAD/DRAIN SHALL abandon queued words; no write issued after deassertion until a new start.

Verification
REQ-034 start, base_addr=0x010; ops add(rs=1,rt=2,rd=3), lw(rs=4,rt=5,imm=0x0008, last), mem_ready=1 -> writes 0x00221820@0x010, 0x8C850008@0x011; done pulse; word_count=2.
REQ-035 mem_ready=0 for 10 cycles, in_valid=1 -> in_ready drops after 4 accepts, mem_we/addr/data stable; release -> 4 words in order.
REQ-036 in_op=28 then j(target=0x0000040, last) -> err=1, only 0x08000040 written, word_count=1.
REQ-037 base_addr=0x3FF, two legal ops -> writes at 0x3FF then 0x000.
REQ-038 rst_n low with 3 words queued and mem_we high -> all outputs zero same cycle; after release no mem_we until start.
REQ-039 FIFO at DEPTH-1, push and pop same cycle -> count stays, sequence intact.
